// File: rtl/player_anim_pkg.sv
// Shared types and frame-index constants for the player sprite animation sequencer.
package player_anim_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    JUMP = 3'd2,
    FALL = 3'd3,
    DEAD = 3'd4
  } anim_state_t;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [IDX_W-1:0] IDX_IDLE  = 4'd0;
  localparam logic [IDX_W-1:0] IDX_RUN0  = 4'd1;
  localparam logic [IDX_W-1:0] IDX_JUMP  = 4'd7;
  localparam logic [IDX_W-1:0] IDX_FALL  = 4'd8;
  localparam logic [IDX_W-1:0] IDX_DEAD0 = 4'd9;

endpackage

// File: rtl/player_anim_ctrl_frame_counter.sv
// Tick-enabled sub-tick/frame counter; frames either wrap or saturate at the last one.
module anim_frame_counter #(
  parameter int unsigned TICKS  = 4,
  parameter int unsigned FRAMES = 6,
  parameter int unsigned W      = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         tick_i,
  input  logic         clr_i,
  input  logic         adv_i,
  input  logic         sat_i,
  output logic [W-1:0] frame_o,
  output logic [W-1:0] frame_nxt_o
);

  localparam int unsigned SUB_W = (TICKS > 1) ? $clog2(TICKS) : 1;

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [W-1:0]     frame_q, frame_d;

  always_comb begin
    sub_d   = sub_q;
    frame_d = frame_q;
    if (clr_i) begin
      sub_d   = '0;
      frame_d = '0;
    end else if (adv_i) begin
      if (sub_q == SUB_W'(TICKS - 1)) begin
        sub_d = '0;
        if (frame_q == W'(FRAMES - 1)) begin
          frame_d = sat_i ? frame_q : '0;
        end else begin
          frame_d = frame_q + 1'b1;
        end
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sub_q   <= '0;
      frame_q <= '0;
    end else if (tick_i) begin
      sub_q   <= sub_d;
      frame_q <= frame_d;
    end
  end

  assign frame_o     = frame_q;
  assign frame_nxt_o = frame_d;

endmodule

// File: rtl/player_anim_ctrl.sv
// Player sprite animation sequencer: motion state, facing and the registered sprite-sheet offset.
module player_anim_ctrl
  import player_anim_pkg::*;
#(
  parameter int unsigned FRAME_SIZE      = 1080,
  parameter int unsigned RIGHT_BASE      = 0,
  parameter int unsigned LEFT_BASE       = 20736,
  parameter int unsigned TICKS_PER_FRAME = 4,
  parameter int unsigned RUN_FRAMES      = 6,
  parameter int unsigned JUMP_TICKS      = 16,
  parameter int unsigned DEATH_FRAMES    = 3
) (
  input  logic        frame_Clk,
  input  logic        Reset,
  input  logic        frameTick,
  input  logic        moveLeft,
  input  logic        moveRight,
  input  logic        jumpReq,
  input  logic        onGround,
  input  logic        hit,
  input  logic        respawn,
  output logic [31:0] animationOffset,
  output logic        playerDirection,
  output logic [2:0]  animState,
  output logic        deadDone
);

  localparam int unsigned JW = $clog2(JUMP_TICKS + 1);

  anim_state_t       state_q, state_d;
  logic              dir_q, dir_d;
  logic [JW-1:0]     jcnt_q, jcnt_d;
  logic [31:0]       offset_q, offset_d;
  logic              dead_done_q, dead_done_d;

  logic              move;
  logic              run_clr, run_adv, dth_clr, dth_adv;
  logic [CNT_W-1:0]  run_frame, run_frame_nxt;
  logic [CNT_W-1:0]  dth_frame, dth_frame_nxt;
  logic [IDX_W-1:0]  idx;

  function automatic logic [31:0] anim_offset(input logic dir, input logic [IDX_W-1:0] fidx);
    logic [31:0] base;
    base = dir ? 32'(LEFT_BASE) : 32'(RIGHT_BASE);
    return base + 32'(fidx) * 32'(FRAME_SIZE);
  endfunction

  assign move = moveLeft ^ moveRight;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    jcnt_d  = jcnt_q;
    dth_clr = 1'b0;
    dth_adv = 1'b0;

    if (hit && state_q != DEAD) begin
      state_d = DEAD;
      dth_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, RUN: begin
          if (jumpReq && onGround) begin
            state_d = JUMP;
            jcnt_d  = '0;
          end else if (!onGround) begin
            state_d = FALL;
          end else begin
            state_d = move ? RUN : IDLE;
          end
        end
        JUMP: begin
          if (jcnt_q == JW'(JUMP_TICKS - 1)) state_d = FALL;
          else                                jcnt_d  = jcnt_q + 1'b1;
        end
        FALL: begin
          if (onGround) state_d = move ? RUN : IDLE;
        end
        DEAD: begin
          dth_adv = 1'b1;
          if (dead_done_q && respawn) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Facing is frozen while dead and forced back to right on respawn.
    if (state_q != DEAD) begin
      if (moveLeft && !moveRight)      dir_d = 1'b1;
      else if (moveRight && !moveLeft) dir_d = 1'b0;
    end else if (state_d == IDLE) begin
      dir_d = 1'b0;
    end

    run_clr = (state_d == RUN) && (state_q != RUN);
    run_adv = (state_d == RUN) && (state_q == RUN);

    unique case (state_d)
      RUN:     idx = IDX_RUN0 + run_frame_nxt;
      JUMP:    idx = IDX_JUMP;
      FALL:    idx = IDX_FALL;
      DEAD:    idx = IDX_DEAD0 + dth_frame_nxt;
      default: idx = IDX_IDLE;
    endcase

    dead_done_d = (state_d == DEAD) && (dth_frame_nxt == CNT_W'(DEATH_FRAMES - 1));
    offset_d    = anim_offset(dir_d, idx);
  end

  anim_frame_counter #(
    .TICKS  (TICKS_PER_FRAME),
    .FRAMES (RUN_FRAMES),
    .W      (CNT_W)
  ) u_run_cnt (
    .clk_i       (frame_Clk),
    .rst_i       (Reset),
    .tick_i      (frameTick),
    .clr_i       (run_clr),
    .adv_i       (run_adv),
    .sat_i       (1'b0),
    .frame_o     (run_frame),
    .frame_nxt_o (run_frame_nxt)
  );

  anim_frame_counter #(
    .TICKS  (TICKS_PER_FRAME),
    .FRAMES (DEATH_FRAMES),
    .W      (CNT_W)
  ) u_dth_cnt (
    .clk_i       (frame_Clk),
    .rst_i       (Reset),
    .tick_i      (frameTick),
    .clr_i       (dth_clr),
    .adv_i       (dth_adv),
    .sat_i       (1'b1),
    .frame_o     (dth_frame),
    .frame_nxt_o (dth_frame_nxt)
  );

  always_ff @(posedge frame_Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      jcnt_q      <= '0;
      offset_q    <= '0;
      dead_done_q <= 1'b0;
    end else if (frameTick) begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      jcnt_q      <= jcnt_d;
      offset_q    <= offset_d;
      dead_done_q <= dead_done_d;
    end
  end

  assign animationOffset = offset_q;
  assign playerDirection = dir_q;
  assign animState       = state_q;
  assign deadDone        = dead_done_q;

  // Registered frame counters are observed only through the next-value path.
  logic unused_ok;
  assign unused_ok = ^{run_frame, dth_frame};

endmodule

// File: tb/tb_player_anim_ctrl.sv
// Directed bench for player_anim_ctrl with hand-computed offsets at default parameters.
module tb_player_anim_ctrl;

  logic        frame_Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frameTick = 1'b0;
  logic        moveLeft = 1'b0, moveRight = 1'b0, jumpReq = 1'b0;
  logic        onGround = 1'b1, hit = 1'b0, respawn = 1'b0;
  logic [31:0] animationOffset;
  logic        playerDirection;
  logic [2:0]  animState;
  logic        deadDone;

  int tests = 0;
  int fails = 0;
  logic [31:0] s_off;
  logic        s_dir, s_done;
  logic [2:0]  s_st;

  player_anim_ctrl dut (
    .frame_Clk       (frame_Clk),
    .Reset           (Reset),
    .frameTick       (frameTick),
    .moveLeft        (moveLeft),
    .moveRight       (moveRight),
    .jumpReq         (jumpReq),
    .onGround        (onGround),
    .hit             (hit),
    .respawn         (respawn),
    .animationOffset (animationOffset),
    .playerDirection (playerDirection),
    .animState       (animState),
    .deadDone        (deadDone)
  );

  always #5 frame_Clk = ~frame_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge frame_Clk);
    frameTick = 1'b1;
    @(negedge frame_Clk);
    frameTick = 1'b0;
  endtask

  task automatic expect4(input string tag, input logic [2:0] st, input logic [31:0] off,
                         input logic dir, input logic done);
    check({tag, ".state"},  32'(animState),       32'(st));
    check({tag, ".offset"}, animationOffset,      off);
    check({tag, ".dir"},    32'(playerDirection), 32'(dir));
    check({tag, ".done"},   32'(deadDone),        32'(done));
  endtask

  initial begin
    // Power-up reset
    tick();
    tick();
    Reset = 1'b0;
    expect4("reset", 3'd0, 32'd0, 1'b0, 1'b0);

    // Run cycle to the right
    moveRight = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      tick();
      if (t == 1)  expect4("run_t1", 3'd1, 32'd1080, 1'b0, 1'b0);
      if (t == 4)  check("run_t4.offset", animationOffset, 32'd1080);
      if (t == 5)  check("run_t5.offset", animationOffset, 32'd2160);
      if (t == 21) check("run_t21.offset", animationOffset, 32'd6480);
      if (t == 25) check("run_t25.offset", animationOffset, 32'd1080);
    end

    // Reset on a tick mid-run
    @(negedge frame_Clk);
    Reset = 1'b1;
    frameTick = 1'b1;
    @(negedge frame_Clk);
    Reset = 1'b0;
    frameTick = 1'b0;
    expect4("reset_midrun", 3'd0, 32'd0, 1'b0, 1'b0);

    // Left then both held
    moveRight = 1'b0;
    moveLeft = 1'b1;
    tick();
    expect4("left", 3'd1, 32'd21816, 1'b1, 1'b0);
    moveRight = 1'b1;
    tick();
    expect4("both", 3'd0, 32'd20736, 1'b1, 1'b0);

    // Jump and fall, right-facing
    moveLeft = 1'b0;
    tick();
    expect4("face_right", 3'd1, 32'd1080, 1'b0, 1'b0);
    moveRight = 1'b0;
    jumpReq = 1'b1;
    tick();
    expect4("jump", 3'd2, 32'd7560, 1'b0, 1'b0);
    jumpReq = 1'b0;
    onGround = 1'b0;
    for (int t = 1; t <= 15; t++) tick();
    check("jump_t15.state", 32'(animState), 32'd2);
    tick();
    expect4("fall", 3'd3, 32'd8640, 1'b0, 1'b0);
    jumpReq = 1'b1;
    tick();
    check("fall_hold.state", 32'(animState), 32'd3);
    jumpReq = 1'b0;
    onGround = 1'b1;
    tick();
    expect4("land", 3'd0, 32'd0, 1'b0, 1'b0);

    // Death sequence
    moveRight = 1'b1;
    tick();
    check("prehit.state", 32'(animState), 32'd1);
    hit = 1'b1;
    tick();
    expect4("dead0", 3'd4, 32'd9720, 1'b0, 1'b0);
    hit = 1'b0;
    moveRight = 1'b0;
    respawn = 1'b1;
    tick();
    check("early_respawn.state", 32'(animState), 32'd4);
    respawn = 1'b0;
    tick();
    tick();
    check("dead_t3.offset", animationOffset, 32'd9720);
    tick();
    expect4("dead1", 3'd4, 32'd10800, 1'b0, 1'b0);
    for (int t = 5; t <= 8; t++) tick();
    expect4("dead2", 3'd4, 32'd11880, 1'b0, 1'b1);
    hit = 1'b1;
    moveLeft = 1'b1;
    tick();
    expect4("dead_hold", 3'd4, 32'd11880, 1'b0, 1'b1);
    hit = 1'b0;
    respawn = 1'b1;
    tick();
    expect4("respawn", 3'd0, 32'd0, 1'b0, 1'b0);
    respawn = 1'b0;

    // Inputs churn without ticks
    tick();
    expect4("pre_churn", 3'd1, 32'd21816, 1'b1, 1'b0);
    s_off = animationOffset;
    s_dir = playerDirection;
    s_st = animState;
    s_done = deadDone;
    for (int c = 0; c < 100; c++) begin
      @(negedge frame_Clk);
      moveLeft  = 1'($urandom);
      moveRight = 1'($urandom);
      jumpReq   = 1'($urandom);
      onGround  = 1'($urandom);
      hit       = 1'($urandom);
      respawn   = 1'($urandom);
    end
    @(negedge frame_Clk);
    expect4("churn", s_st, s_off, s_dir, s_done);

    // Hit beats jump on the same tick
    moveLeft = 1'b0;
    moveRight = 1'b0;
    onGround = 1'b1;
    respawn = 1'b0;
    hit = 1'b1;
    jumpReq = 1'b1;
    tick();
    expect4("hit_vs_jump", 3'd4, 32'd30456, 1'b1, 1'b0);

    // Reset while dead
    hit = 1'b0;
    jumpReq = 1'b0;
    @(negedge frame_Clk);
    Reset = 1'b1;
    frameTick = 1'b1;
    @(negedge frame_Clk);
    Reset = 1'b0;
    frameTick = 1'b0;
    expect4("reset_dead", 3'd0, 32'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/player_anim_ctrl.md
Name: player_anim_ctrl

Overview:
Animation sequencer for the player sprite. It tracks the player's motion state and facing direction, and steps through run and death frames. It produces the registered animationOffset and playerDirection that feed the player sprite address generator. All updates are gated to the per-frame tick so the sprite never changes offset mid-frame.

Parameters:
FRAME_SIZE, 1080, words per sprite frame (24 x 45 pixels).
RIGHT_BASE, 0, sheet base address of right-facing frames.
LEFT_BASE, 20736, sheet base address of left-facing frames.
TICKS_PER_FRAME, 4, frameTick count per animation frame (run and death).
RUN_FRAMES, 6, number of run-cycle frames.
JUMP_TICKS, 16, frameTicks spent in JUMP before FALL.
DEATH_FRAMES, 3, number of death frames.

Ports:
frame_Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frameTick  in  1  one-cycle strobe at vertical blank; the only cycles on which state advances
moveLeft  in  1  left control held
moveRight  in  1  right control held
jumpReq  in  1  jump control held
onGround  in  1  player is standing on terrain (from the physics block)
hit  in  1  player was struck this frame
respawn  in  1  game logic requests respawn
animationOffset  out  32  sprite-sheet base address of the current frame, registered
playerDirection  out  1  0 = right, 1 = left, registered
animState  out  3  current state encoding
deadDone  out  1  death animation finished, waiting for respawn

Behaviour:
- Clocking and reset:
  - Single clock frame_Clk. Reset is synchronous and active-high.
  - Reset forces state IDLE, direction 0, all counters 0, animationOffset 0, deadDone 0.
  - Reset overrides frameTick and is honoured in any state, including mid-jump or mid-death.
- Tick gating:
  - With frameTick=0, every register holds, whatever the other inputs do.
  - On a frameTick cycle, next state, counters, direction and offset all register together.
  - Outputs show the new values one clock after the tick edge.
- Move decode:
  - move = moveLeft XOR moveRight. Both held means no move.
- Direction (tick cycles only, not in DEAD):
  - moveLeft && !moveRight sets direction 1.
  - moveRight && !moveLeft sets direction 0.
  - Otherwise direction holds.
- States: IDLE, RUN, JUMP, FALL, DEAD. Transition priority on each tick:
  1. hit && state!=DEAD → DEAD. Death counters clear.
  2. IDLE/RUN:
     - jumpReq && onGround → JUMP, jump counter cleared.
     - else !onGround → FALL.
     - else move → RUN; else IDLE.
  3. JUMP:
     - Jump counter increments each tick.
     - When it reaches JUMP_TICKS-1 → FALL.
     - jumpReq and onGround are ignored.
  4. FALL:
     - onGround → RUN if move, else IDLE.
     - jumpReq is ignored.
  5. DEAD:
     - The sub-tick counter advances each tick.
     - At TICKS_PER_FRAME-1 it wraps and the death frame increments, saturating at DEATH_FRAMES-1.
     - deadDone = 1 while the last frame is held; it is cleared otherwise.
     - respawn is accepted only when deadDone=1 → IDLE, direction 0.
     - hit is ignored while in DEAD.
- Run cycle:
  - Entering RUN from any other state clears the sub-tick counter and runFrame to 0.
  - While in RUN, the sub-tick counter wraps at TICKS_PER_FRAME-1 and runFrame increments modulo RUN_FRAMES.
- Frame index:
  - IDLE = 0.
  - RUN = 1 + runFrame.
  - JUMP = 7.
  - FALL = 8.
  - DEAD = 9 + deathFrame.
- Offset:
  - animationOffset = (direction ? LEFT_BASE : RIGHT_BASE) + frameIndex × FRAME_SIZE.
  - It is computed from the next state, direction and counters, and registered on the tick.
  - Unsigned 32-bit arithmetic with no overflow at the default parameters (maximum 20736 + 11 × 1080).
- animState tracks the registered state; deadDone is registered.

Decomposition:
- Package player_anim_pkg holds:
  - the anim_state_t enum (IDLE=0, RUN=1, JUMP=2, FALL=3, DEAD=4);
  - the frame-index constants (IDX_IDLE, IDX_RUN0, IDX_JUMP, IDX_FALL, IDX_DEAD0).
- One sub-module, anim_frame_counter:
  - tick-enabled sub-tick and frame counter;
  - clear input, wrap or saturate mode select;
  - used for both the run cycle and the death sequence.

Test Plan:
1. Reset asserted mid-RUN on a frameTick cycle → next cycle offset 0, direction 0, state IDLE, deadDone 0.
2. onGround=1 with moveRight held, 25 frameTicks:
   - after tick 1, state RUN and offset 1080;
   - after tick 5, offset 2160;
   - after tick 21, offset 6480;
   - after tick 25, wrapped back to 1080.
3. moveLeft held for 1 tick → RUN, direction 1, offset 21816. Both controls held next tick → IDLE, direction stays 1, offset 20736.
4. jumpReq with onGround=1:
   - JUMP, offset 7560;
   - after 16 ticks (onGround=0), FALL, offset 8640;
   - onGround=1 with no move → IDLE, offset 0.
5. hit during RUN (right-facing):
   - DEAD, offset 9720;
   - 10800 after 4 more ticks;
   - 11880 and deadDone=1 after 8;
   - respawn → IDLE, offset 0.
   - A respawn pulsed before deadDone=1 is ignored.
6. Toggle every control input with frameTick=0 for 100 cycles → all outputs unchanged. A hit and jumpReq on the same tick → DEAD wins.
